// File: rtl/dma_pkg.sv
// Shared types and command encodings for the single-channel word-copy DMA engine.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } dma_state_e;

  localparam logic [2:0] DMA_COPY  = 3'b000;
  localparam logic [2:0] DMA_DRAIN = 3'b001;

  localparam logic [3:0] FULL_WORD = 4'b1111;

  function automatic logic is_legal(input logic [2:0] funct3);
    return (funct3 == DMA_COPY) || (funct3 == DMA_DRAIN);
  endfunction

endpackage

// File: rtl/dma_ctrl.sv
// Word-by-word DMA engine driven from the core EX stage: read one word, write it
// back out, repeat; DRAIN mode keeps the destination fixed for a peripheral FIFO.
module dma_ctrl
  import dma_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            dma_en_i,
  input  logic [2:0]      dma_funct3_i,
  input  logic [11:0]     dma_imm_i,
  input  logic [XLEN-1:0] dma_rs1_i,
  input  logic [XLEN-1:0] dma_rs2_i,
  output logic            dma_busy_o,
  output logic            dma_done_o,
  output logic            dma_err_o,
  output logic            req_o,
  input  logic            gnt_i,
  output logic [XLEN-1:0] addr_o,
  output logic [XLEN-1:0] wr_data_o,
  input  logic [XLEN-1:0] rd_data_i,
  output logic [3:0]      size_o,
  output logic            read_o,
  output logic            write_o
);

  localparam logic [XLEN-1:0] WORD_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  dma_state_e      state_reg, state_next;
  logic [XLEN-1:0] src_reg;
  logic [XLEN-1:0] dst_reg;
  logic [XLEN-1:0] data_buf_reg;
  logic [11:0]     cnt_reg;
  logic            drain_reg;
  logic            err_reg;
  logic            start;

  // A command only starts a transfer when it is legal and moves at least one word.
  assign start = dma_en_i && is_legal(dma_funct3_i) && (dma_imm_i != 12'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RD_REQ;
      RD_REQ:  if (gnt_i) state_next = RD_WAIT;
      RD_WAIT: state_next = WR_REQ;
      WR_REQ:  if (gnt_i) state_next = (cnt_reg == 12'd1) ? DONE : RD_REQ;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_o      = 1'b0;
    read_o     = 1'b0;
    write_o    = 1'b0;
    size_o     = 4'b0000;
    addr_o     = '0;
    wr_data_o  = '0;
    dma_busy_o = (state_reg != IDLE);
    dma_done_o = (state_reg == DONE);
    dma_err_o  = err_reg;
    case (state_reg)
      RD_REQ: begin
        req_o  = 1'b1;
        read_o = 1'b1;
        addr_o = src_reg;
        size_o = FULL_WORD;
      end
      WR_REQ: begin
        req_o     = 1'b1;
        write_o   = 1'b1;
        addr_o    = dst_reg;
        wr_data_o = data_buf_reg;
        size_o    = FULL_WORD;
      end
      default: ;
    endcase
  end

  // Datapath: command latch, read-data capture and per-word address stepping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_reg      <= '0;
      dst_reg      <= '0;
      data_buf_reg <= '0;
      cnt_reg      <= '0;
      drain_reg    <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (dma_en_i && !is_legal(dma_funct3_i)) begin
            err_reg <= 1'b1;
          end else if (start) begin
            err_reg   <= 1'b0;
            src_reg   <= dma_rs1_i & ALIGN_MASK;
            dst_reg   <= dma_rs2_i & ALIGN_MASK;
            cnt_reg   <= dma_imm_i;
            drain_reg <= (dma_funct3_i == DMA_DRAIN);
          end
        end
        RD_WAIT: data_buf_reg <= rd_data_i;
        WR_REQ: begin
          if (gnt_i) begin
            cnt_reg <= cnt_reg - 12'd1;
            src_reg <= src_reg + WORD_STEP;
            if (!drain_reg) dst_reg <= dst_reg + WORD_STEP;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// Scoreboard bench for dma_ctrl: a memory model answers reads, expected bus
// transactions come from a word-list model of each command.
module tb_dma_ctrl;
  import dma_pkg::*;

  localparam int XLEN = 32;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        dma_en_i = 1'b0;
  logic [2:0]  dma_funct3_i = 3'b000;
  logic [11:0] dma_imm_i = 12'd0;
  logic [31:0] dma_rs1_i = 32'd0;
  logic [31:0] dma_rs2_i = 32'd0;
  logic        gnt_i = 1'b0;
  logic [31:0] rd_data_i = 32'd0;
  logic        dma_busy_o, dma_done_o, dma_err_o;
  logic        req_o, read_o, write_o;
  logic [31:0] addr_o, wr_data_o;
  logic [3:0]  size_o;

  dma_ctrl #(.XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .dma_en_i(dma_en_i), .dma_funct3_i(dma_funct3_i),
    .dma_imm_i(dma_imm_i), .dma_rs1_i(dma_rs1_i), .dma_rs2_i(dma_rs2_i),
    .dma_busy_o(dma_busy_o), .dma_done_o(dma_done_o), .dma_err_o(dma_err_o),
    .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .wr_data_o(wr_data_o),
    .rd_data_i(rd_data_i), .size_o(size_o), .read_o(read_o), .write_o(write_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_rd_q[$];
  wr_t         exp_wr_q[$];
  wr_t         wr_exp;
  logic        exp_err = 1'b0;
  int          exp_done = 0;
  int          done_seen = 0;
  int          busy_cycles = 0;
  int          req_cnt = 0;
  bit          gnt_manual = 1'b1;
  bit          gnt_random = 1'b0;
  bit          rd_pending = 1'b0;
  logic [31:0] rd_value = 32'd0;

  logic        prev_valid = 1'b0;
  logic        prev_req, prev_gnt, prev_done, prev_rd, prev_wr;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_size;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  always @(posedge clk_i) begin
    #1;
    if (!gnt_manual) gnt_i = gnt_random ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Read data appears in the cycle after the grant; garbage otherwise.
  always @(posedge clk_i) begin
    #1;
    if (rd_pending) begin
      rd_data_i = rd_value;
      rd_pending = 1'b0;
    end else begin
      rd_data_i = $urandom;
    end
  end

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prev_valid = 1'b0;
    end else begin
      if (dma_busy_o) busy_cycles++;
      if (req_o) begin
        req_cnt++;
        check("req_kind", 32'(read_o ^ write_o), 32'd1);
      end else begin
        check("idle_bus", 32'({read_o, write_o, size_o}), 32'd0);
      end
      if (req_o && gnt_i && read_o) begin
        if (exp_rd_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_read: addr 0x%08h, none expected", addr_o);
        end else begin
          check("read_addr", addr_o, exp_rd_q.pop_front());
          check("read_size", 32'(size_o), 32'hF);
        end
        rd_value = mem_val(addr_o);
        rd_pending = 1'b1;
      end
      if (req_o && gnt_i && write_o) begin
        if (exp_wr_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected", addr_o, wr_data_o);
        end else begin
          wr_exp = exp_wr_q.pop_front();
          check("write_addr", addr_o, wr_exp.addr);
          check("write_data", wr_data_o, wr_exp.data);
          check("write_size", 32'(size_o), 32'hF);
        end
      end
      if (prev_valid && prev_req && !prev_gnt) begin
        check("stall_addr", addr_o, prev_addr);
        check("stall_wdata", wr_data_o, prev_wdata);
        check("stall_ctrl", 32'({req_o, read_o, write_o, size_o}),
              32'({prev_req, prev_rd, prev_wr, prev_size}));
      end
      if (dma_done_o) begin
        done_seen++;
        check("done_width", 32'(prev_valid && prev_done), 32'd0);
        check("done_busy", 32'(dma_busy_o), 32'd1);
      end
      prev_req = req_o; prev_gnt = gnt_i; prev_done = dma_done_o;
      prev_rd = read_o; prev_wr = write_o; prev_size = size_o;
      prev_addr = addr_o; prev_wdata = wr_data_o;
      prev_valid = 1'b1;
    end
  end

  // Model: word k reads src+4k; COPY writes dst+4k, DRAIN always writes dst.
  task automatic issue(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                       input int imm);
    bit          legal;
    logic [31:0] s, d;
    wr_t         w;
    legal = (f3 == DMA_COPY) || (f3 == DMA_DRAIN);
    if (!legal) begin
      exp_err = 1'b1;
    end else if (imm > 0) begin
      exp_err = 1'b0;
      exp_done++;
      for (int k = 0; k < imm; k++) begin
        s = (rs1 & 32'hFFFF_FFFC) + 32'(4 * k);
        d = (f3 == DMA_COPY) ? (rs2 & 32'hFFFF_FFFC) + 32'(4 * k) : (rs2 & 32'hFFFF_FFFC);
        exp_rd_q.push_back(s);
        w.addr = d;
        w.data = mem_val(s);
        exp_wr_q.push_back(w);
      end
    end
    @(posedge clk_i); #1;
    busy_cycles = 0;
    dma_en_i = 1'b1; dma_funct3_i = f3; dma_imm_i = 12'(imm);
    dma_rs1_i = rs1; dma_rs2_i = rs2;
    @(posedge clk_i); #1;
    dma_en_i = 1'b0; dma_funct3_i = 3'($urandom); dma_imm_i = 12'($urandom);
    dma_rs1_i = $urandom; dma_rs2_i = $urandom;
    check("err_flag", 32'(dma_err_o), 32'(exp_err));
    check("busy_start", 32'(dma_busy_o), 32'(legal && imm > 0));
    $display("cmd f3=%0b rs1=0x%08h rs2=0x%08h imm=%0d", f3, rs1, rs2, imm);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (dma_busy_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    if (dma_busy_o) begin
      n_checks++; n_errors++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", budget);
    end
    check("rd_left", 32'(exp_rd_q.size()), 32'd0);
    check("wr_left", 32'(exp_wr_q.size()), 32'd0);
    check("done_count", 32'(done_seen), 32'(exp_done));
  endtask

  initial begin
    int nrd;
    int req_snap;
    logic [2:0] f3;
    logic [31:0] rs1;

    repeat (3) @(posedge clk_i);
    #1;
    check("reset_ctrl", 32'({dma_busy_o, dma_done_o, dma_err_o, req_o, read_o, write_o, size_o}), 32'd0);
    check("reset_addr", addr_o, 32'd0);
    check("reset_wdata", wr_data_o, 32'd0);
    rst_ni = 1'b1;
    gnt_manual = 1'b0;
    gnt_random = 1'b0;

    issue(DMA_COPY, 32'h0000_0100, 32'h0000_0200, 2);
    wait_idle(100);
    check("copy2_busy_cycles", 32'(busy_cycles), 32'd7);

    issue(DMA_DRAIN, 32'h0000_0103, 32'h4000_0000, 3);
    wait_idle(100);
    check("drain3_busy_cycles", 32'(busy_cycles), 32'd10);

    issue(DMA_COPY, 32'hFFFF_FFFC, 32'h0000_0300, 2);
    wait_idle(100);

    issue(3'b111, 32'h0000_0400, 32'h0000_0500, 3);
    repeat (3) begin
      @(negedge clk_i);
      check("illegal_busy", 32'(dma_busy_o), 32'd0);
      check("illegal_err_sticky", 32'(dma_err_o), 32'd1);
    end
    wait_idle(10);
    issue(DMA_COPY, 32'h0000_0600, 32'h0000_0700, 0);
    wait_idle(10);
    issue(DMA_COPY, 32'h0000_0800, 32'h0000_0900, 1);
    wait_idle(100);
    check("err_cleared", 32'(dma_err_o), 32'd0);

    // Write-grant stall of five cycles.
    gnt_manual = 1'b1;
    gnt_i = 1'b1;
    issue(DMA_COPY, 32'h0000_0A00, 32'h0000_0B00, 1);
    nrd = 0;
    while (!write_o && nrd < 10) begin
      @(posedge clk_i); #1;
      nrd++;
    end
    check("reached_wr_req", 32'(write_o), 32'd1);
    gnt_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    gnt_i = 1'b1;
    wait_idle(100);
    check("stall_busy_cycles", 32'(busy_cycles), 32'd9);
    gnt_manual = 1'b0;

    // Commands during a transfer are dropped.
    issue(DMA_COPY, 32'h0000_0C00, 32'h0000_0D00, 3);
    dma_en_i = 1'b1; dma_funct3_i = 3'b111; dma_imm_i = 12'd5;
    @(posedge clk_i); #1;
    dma_funct3_i = DMA_COPY;
    @(posedge clk_i); #1;
    dma_en_i = 1'b0;
    wait_idle(100);
    check("busy_cmd_ignored_err", 32'(dma_err_o), 32'd0);
    check("busy_cmd_ignored_cycles", 32'(busy_cycles), 32'd10);

    // Reset during RD_WAIT of word 2 of 4.
    issue(DMA_COPY, 32'h0000_0E00, 32'h0000_0F00, 4);
    nrd = 1;
    for (int i = 0; i < 20 && nrd < 2; i++) begin
      @(posedge clk_i); #1;
      if (read_o) nrd++;
    end
    @(posedge clk_i); #1;
    check("in_rd_wait", 32'({dma_busy_o, req_o}), 32'b10);
    rst_ni = 1'b0;
    #1;
    check("abort_ctrl", 32'({dma_busy_o, dma_done_o, dma_err_o, req_o, read_o, write_o, size_o}), 32'd0);
    check("abort_addr", addr_o, 32'd0);
    check("abort_point_rd", 32'(exp_rd_q.size()), 32'd2);
    check("abort_point_wr", 32'(exp_wr_q.size()), 32'd3);
    exp_rd_q.delete();
    exp_wr_q.delete();
    exp_done--;
    exp_err = 1'b0;
    req_snap = req_cnt;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;
    check("post_reset_reqs", 32'(req_cnt - req_snap), 32'd0);
    check("post_reset_busy", 32'(dma_busy_o), 32'd0);
    wait_idle(10);

    gnt_random = 1'b1;
    for (int t = 0; t < 25; t++) begin
      f3 = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 1)) : 3'($urandom);
      rs1 = (t % 5 == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      issue(f3, rs1, $urandom, $urandom_range(0, 6));
      wait_idle(400);
      check("rand_err", 32'(dma_err_o), 32'(exp_err));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dma_ctrl.md
DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data and address width.
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port dma_en_i, input, 1, command strobe from the core EX stage.
REQ-005 SHALL have port dma_funct3_i, input, 3, operation select.
REQ-006 SHALL have port dma_imm_i, input, 12, transfer length in words.
REQ-007 SHALL have port dma_rs1_i, input, XLEN, source byte address.
REQ-008 SHALL have port dma_rs2_i, input, XLEN, destination byte address.
REQ-009 SHALL have port dma_busy_o, output, 1, transfer in progress; drives the core's dma_busy_i.
REQ-010 SHALL have port dma_done_o, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port dma_err_o, output, 1, sticky illegal-command flag.
REQ-012 SHALL have port req_o, input gnt_i, each 1, data-memory request and grant.
REQ-013 SHALL have ports addr_o, wr_data_o (outputs, XLEN) and rd_data_i (input, XLEN).
REQ-014 SHALL have ports size_o (output, 4, byte enables), read_o and write_o (outputs, 1 each).

Function
REQ-015 SHALL implement states IDLE, RD_REQ, RD_WAIT, WR_REQ and DONE.
REQ-016 SHALL sample the command in IDLE when dma_en_i=1, and only then.
REQ-017 SHALL latch src=rs1 and dst=rs2, with bits [1:0] forced to 0, and cnt=imm.
REQ-018 funct3 000 (COPY) SHALL increment both src and dst by 4 per word.
REQ-019 funct3 001 (DRAIN) SHALL increment only src; dst is held fixed for a peripheral FIFO.
REQ-020 For any other funct3, SHALL set dma_err_o, perform no transfer and remain in IDLE.
REQ-021 A command with imm=0 SHALL perform no transfer, leave busy low and remain in IDLE.
REQ-022 A legal command with imm>0 SHALL go to RD_REQ on the next edge; dma_err_o SHALL clear on that edge.
REQ-023 In RD_REQ: req_o=1, read_o=1, addr_o=src, size_o=4'b1111; on gnt_i=1, go to RD_WAIT.
REQ-024 In RD_WAIT: capture rd_data_i (valid one cycle after the grant) into buf, then go to WR_REQ.
REQ-025 In WR_REQ: req_o=1, write_o=1, addr_o=dst, wr_data_o=buf, size_o=4'b1111.
REQ-026 On gnt_i=1 in WR_REQ: decrement cnt and advance addresses; go to DONE if cnt was 1, otherwise to RD_REQ.
REQ-027 While gnt_i=0, the state and all request outputs SHALL hold unchanged.
REQ-028 In DONE: dma_done_o=1 for exactly one cycle, then go to IDLE.
REQ-029 dma_busy_o SHALL be 1 in every state except IDLE.
REQ-030 Latency: with gnt_i tied to 1, N words SHALL take 3N+1 busy cycles.
REQ-031 Address arithmetic SHALL be modulo 2^XLEN; wrap past 0xFFFF_FFFC to 0x0000_0000 silently.
REQ-032 dma_en_i asserted while busy SHALL be ignored; no queueing.
REQ-033 Outside RD_REQ and WR_REQ: req_o, read_o, write_o=0 and size_o=0.

Reset
REQ-034 On rst_ni=0, SHALL reset asynchronously: state=IDLE, all outputs 0, src, dst, cnt and buf cleared, dma_err_o=0.
REQ-035 Reset mid-transfer SHALL abort immediately with no further requests; the remaining words are discarded.

Structure
REQ-036 Package dma_pkg SHALL hold the state enum and the funct3 constants DMA_COPY=3'b000 and DMA_DRAIN=3'b001.
REQ-037 SHALL be a single flat module with no sub-module.

Verification
REQ-038 COPY, rs1=0x100, rs2=0x200, imm=2, gnt_i=1: reads at 0x100 and 0x104, writes at 0x200 and 0x204, busy high for 7 cycles, done pulsed once.
REQ-039 DRAIN, rs1=0x103, rs2=0x4000_0000, imm=3: reads at 0x100, 0x104 and 0x108; all three writes at 0x4000_0000.
REQ-040 gnt_i held low for 5 cycles in WR_REQ: addr_o, wr_data_o and write_o stable throughout; completion delayed 5 cycles.
REQ-041 funct3=3'b111 -> dma_err_o=1 and busy stays 0; a following legal COPY clears err.
REQ-042 rs1=0xFFFF_FFFC, imm=2 (COPY) -> second read at 0x0000_0000.
REQ-043 rst_ni low during RD_WAIT of word 2 of 4 -> all outputs 0 immediately; no writes after reset release.
